// File: rtl/bsg_manycore_stat_snoop_pkg.sv
// rtl/bsg_manycore_stat_snoop_pkg.sv - shared constants, record type and helpers for the print-stat snoop
// Purpose: default print-stat EPA, default-width record layout {ch, stamp, tag},
//          and the channel-id width helper used by the top and the bench.
// Ports:   none (package).
package bsg_manycore_stat_snoop_pkg;

   localparam longint unsigned stat_epa_default = 64'd0;

   localparam int def_ch_width_lp    = 1;
   localparam int def_stamp_width_lp = 64;
   localparam int def_tag_width_lp   = 32;

   typedef struct packed {
      logic [def_ch_width_lp-1:0]    ch;
      logic [def_stamp_width_lp-1:0] stamp;
      logic [def_tag_width_lp-1:0]   tag;
   } stat_rec_s;

   // A single channel still needs a one-bit id field.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_manycore_stat_snoop_fifo.sv
// rtl/bsg_manycore_stat_snoop_fifo.sv - els_p-entry 1r1w record FIFO with valid/ready output
// Purpose: buffers snooped records; a push is accepted on a full FIFO when the
//          head is popped in the same cycle.
// Ports:   clk_i, reset_n_i (async active-low)
//          push_v_i, push_data_i : write request (caller only asserts when accepted)
//          full_o                : no free entry this cycle
//          v_o, data_o, ready_i  : head record, zero while empty
module bsg_manycore_stat_snoop_fifo #(
   parameter int width_p = 8,
   parameter int els_p   = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_v_i,
   input  logic [width_p-1:0] push_data_i,
   output logic               full_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i
);

   localparam int ptr_w_lp = $clog2(els_p);

   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
   logic [ptr_w_lp:0]   count;
   logic                push, pop;

   assign v_o    = (count != '0);
   assign full_o = (count == (ptr_w_lp+1)'(els_p));
   assign pop    = v_o & ready_i;
   assign push   = push_v_i & (~full_o | pop);
   // Gating keeps the record outputs at zero after reset even though mem is not cleared.
   assign data_o = v_o ? mem[rd_ptr] : '0;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_data_i;
   end

   // Pointers wrap naturally because els_p is a power of two.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_w_lp'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_w_lp'(1);
         count <= count + (ptr_w_lp+1)'(push) - (ptr_w_lp+1)'(pop);
      end
   end

endmodule

// File: rtl/bsg_manycore_stat_snoop_mc.sv
// rtl/bsg_manycore_stat_snoop_mc.sv - multi-channel timestamped print-stat snoop with record FIFO
// Purpose: flags stores to the print-stat EPA on num_ch_p request streams, stamps
//          them with a free-running cycle counter, parks them in per-channel
//          holding registers and round-robins them into a record FIFO.
// Ports:   clk_i, reset_n_i (async active-low)
//          pkt_v_i, pkt_store_i, pkt_addr_i, pkt_data_i : snooped request streams
//          v_o, ready_i, ch_o, stamp_o, tag_o           : record output
//          drop_cnt_o                                   : per-channel drop counts
// Config:  BSG_STAT_SNOOP_DROP_COUNT_EN enables saturating drop counters;
//          otherwise drop_cnt_o is tied to zero.
module bsg_manycore_stat_snoop_mc
   import bsg_manycore_stat_snoop_pkg::*;
#(
   parameter int              num_ch_p         = 2,
   parameter int              addr_width_p     = 28,
   parameter int              data_width_p     = 32,
   parameter longint unsigned stat_epa_p       = stat_epa_default,
   parameter int              stamp_width_p    = 64,
   parameter int              fifo_els_p       = 8,
   parameter int              drop_cnt_width_p = 16,
   localparam int             ch_width_lp      = ch_width(num_ch_p)
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [num_ch_p-1:0]                  pkt_v_i,
   input  logic [num_ch_p-1:0]                  pkt_store_i,
   input  logic [num_ch_p*addr_width_p-1:0]     pkt_addr_i,
   input  logic [num_ch_p*data_width_p-1:0]     pkt_data_i,
   output logic                                 v_o,
   input  logic                                 ready_i,
   output logic [ch_width_lp-1:0]               ch_o,
   output logic [stamp_width_p-1:0]             stamp_o,
   output logic [data_width_p-1:0]              tag_o,
   output logic [num_ch_p*drop_cnt_width_p-1:0] drop_cnt_o
);

   localparam int rec_width_lp = ch_width_lp + stamp_width_p + data_width_p;
   localparam logic [addr_width_p-1:0] epa_lp = addr_width_p'(stat_epa_p);

   logic [stamp_width_p-1:0] stamp_r;
   logic [num_ch_p-1:0]      match;
   logic [num_ch_p-1:0]      hold_v;
   logic [stamp_width_p-1:0] hold_stamp [num_ch_p];
   logic [data_width_p-1:0]  hold_tag   [num_ch_p];
   logic [ch_width_lp-1:0]   rr_ptr;
   logic                     gnt_v;
   logic [ch_width_lp-1:0]   gnt_id;
   logic [num_ch_p-1:0]      gnt_oh;
   logic                     fifo_full, fifo_v, push_ok;
   logic [rec_width_lp-1:0]  fifo_data;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) stamp_r <= '0;
      else            stamp_r <= stamp_r + stamp_width_p'(1);
   end

   always_comb begin
      match = '0;
      for (int c = 0; c < num_ch_p; c++) begin
         match[c] = pkt_v_i[c] & pkt_store_i[c]
                  & (pkt_addr_i[c*addr_width_p +: addr_width_p] == epa_lp);
      end
   end

   // A grant is allowed when the FIFO has room or its head leaves this cycle.
   assign push_ok = ~fifo_full | (fifo_v & ready_i);

   // Round-robin: first occupied holding register at or after rr_ptr.
   always_comb begin
      int idx;
      gnt_v  = 1'b0;
      gnt_id = '0;
      idx    = 0;
      if (push_ok) begin
         for (int i = 0; i < num_ch_p; i++) begin
            idx = (int'(rr_ptr) + i) % num_ch_p;
            if (!gnt_v && hold_v[idx]) begin
               gnt_v  = 1'b1;
               gnt_id = ch_width_lp'(idx);
            end
         end
      end
   end

   always_comb begin
      gnt_oh = '0;
      for (int c = 0; c < num_ch_p; c++) begin
         gnt_oh[c] = gnt_v & (gnt_id == ch_width_lp'(c));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr <= '0;
      end else if (gnt_v) begin
         rr_ptr <= (gnt_id == ch_width_lp'(num_ch_p-1)) ? '0 : gnt_id + ch_width_lp'(1);
      end
   end

   // A register granted this cycle frees at the edge and may take a same-cycle match.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold_v <= '0;
         for (int c = 0; c < num_ch_p; c++) begin
            hold_stamp[c] <= '0;
            hold_tag[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < num_ch_p; c++) begin
            if (match[c] && (!hold_v[c] || gnt_oh[c])) begin
               hold_v[c]     <= 1'b1;
               hold_stamp[c] <= stamp_r;
               hold_tag[c]   <= pkt_data_i[c*data_width_p +: data_width_p];
            end else if (gnt_oh[c]) begin
               hold_v[c] <= 1'b0;
            end
         end
      end
   end

   bsg_manycore_stat_snoop_fifo #(
      .width_p (rec_width_lp),
      .els_p   (fifo_els_p)
   ) fifo (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_v_i    (gnt_v),
      .push_data_i ({gnt_id, hold_stamp[gnt_id], hold_tag[gnt_id]}),
      .full_o      (fifo_full),
      .v_o         (fifo_v),
      .data_o      (fifo_data),
      .ready_i     (ready_i)
   );

   assign v_o = fifo_v;
   assign {ch_o, stamp_o, tag_o} = fifo_data;

`ifdef BSG_STAT_SNOOP_DROP_COUNT_EN
   logic [num_ch_p-1:0]         drop;
   logic [drop_cnt_width_p-1:0] drop_cnt_r [num_ch_p];

   assign drop = match & hold_v & ~gnt_oh;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int c = 0; c < num_ch_p; c++) drop_cnt_r[c] <= '0;
      end else begin
         for (int c = 0; c < num_ch_p; c++) begin
            if (drop[c] && (drop_cnt_r[c] != '1))
               drop_cnt_r[c] <= drop_cnt_r[c] + drop_cnt_width_p'(1);
         end
      end
   end

   always_comb begin
      drop_cnt_o = '0;
      for (int c = 0; c < num_ch_p; c++) begin
         drop_cnt_o[c*drop_cnt_width_p +: drop_cnt_width_p] = drop_cnt_r[c];
      end
   end
`else
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_stat_snoop_mc.sv
// tb/tb_bsg_manycore_stat_snoop_mc.sv - self-checking bench for the print-stat snoop
module tb_bsg_manycore_stat_snoop_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [1:0]  pkt_v, pkt_store;
   logic [55:0] pkt_addr;
   logic [63:0] pkt_data;
   logic        ready;
   logic        v;
   logic [0:0]  ch;
   logic [63:0] stamp;
   logic [31:0] tag;
   logic [31:0] drop_cnt;

   logic        w_pkt_v;
   logic        w_store;
   logic [27:0] w_addr;
   logic [31:0] w_data;
   logic        w_ready;
   logic        w_v;
   logic [0:0]  w_ch;
   logic [3:0]  w_stamp;
   logic [31:0] w_tag;
   logic [15:0] w_drop;

   bsg_manycore_stat_snoop_mc dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .pkt_v_i     (pkt_v),
      .pkt_store_i (pkt_store),
      .pkt_addr_i  (pkt_addr),
      .pkt_data_i  (pkt_data),
      .v_o         (v),
      .ready_i     (ready),
      .ch_o        (ch),
      .stamp_o     (stamp),
      .tag_o       (tag),
      .drop_cnt_o  (drop_cnt)
   );

   bsg_manycore_stat_snoop_mc #(
      .num_ch_p      (1),
      .stamp_width_p (4),
      .fifo_els_p    (2)
   ) dut_wrap (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .pkt_v_i     (w_pkt_v),
      .pkt_store_i (w_store),
      .pkt_addr_i  (w_addr),
      .pkt_data_i  (w_data),
      .v_o         (w_v),
      .ready_i     (w_ready),
      .ch_o        (w_ch),
      .stamp_o     (w_stamp),
      .tag_o       (w_tag),
      .drop_cnt_o  (w_drop)
   );

   typedef struct {
      int              ch;
      longint unsigned stamp;
      logic [31:0]     tag;
   } rec_t;

   rec_t            q[$];
   bit              hv[2];
   rec_t            hr[2];
   int              ptr;
   longint unsigned cnt;
   int              drops[2];
   int              n_assert = 0;
   int              n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      hv[0] = 1'b0; hv[1] = 1'b0;
      ptr = 0; cnt = 0;
      drops[0] = 0; drops[1] = 0;
   endtask

   function automatic logic [31:0] exp_drop();
      logic [31:0] r;
      int d0, d1;
      d0 = drops[0]; d1 = drops[1];
`ifdef BSG_STAT_SNOOP_DROP_COUNT_EN
      r = {d1[15:0], d0[15:0]};
`else
      r = 32'd0;
`endif
      return r;
   endfunction

   // One clock cycle: drive at posedge+1, compare and advance the model at negedge.
   task automatic do_cycle(input logic [1:0] v_in, input logic [1:0] st_in,
                           input logic [27:0] a0, input logic [27:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic rdy);
      bit   m[2];
      bit   pop, space;
      int   g;
      rec_t r;
      pkt_v = v_in; pkt_store = st_in;
      pkt_addr = {a1, a0}; pkt_data = {d1, d0}; ready = rdy;
      @(negedge clk);
      chk("v_o", 64'(v), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("ch_o", 64'(ch), 64'(q[0].ch));
         chk("stamp_o", stamp, q[0].stamp);
         chk("tag_o", 64'(tag), 64'(q[0].tag));
      end
      chk("drop_cnt_o", 64'(drop_cnt), 64'(exp_drop()));
      m[0] = v_in[0] && st_in[0] && (a0 == 28'd0);
      m[1] = v_in[1] && st_in[1] && (a1 == 28'd0);
      pop   = (q.size() > 0) && rdy;
      space = (q.size() < 8) || pop;
      g = -1;
      if (space) begin
         for (int i = 0; i < 2; i++)
            if (g < 0 && hv[(ptr + i) % 2]) g = (ptr + i) % 2;
      end
      for (int c = 0; c < 2; c++)
         if (m[c] && hv[c] && g != c && drops[c] < 65535) drops[c]++;
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back(hr[g]);
         hv[g] = 1'b0;
         ptr = (g + 1) % 2;
      end
      for (int c = 0; c < 2; c++) begin
         if (m[c] && !hv[c]) begin
            r.ch = c; r.stamp = cnt; r.tag = (c == 0) ? d0 : d1;
            hv[c] = 1'b1;
            hr[c] = r;
         end
      end
      cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      do_cycle(2'b00, 2'b00, 28'd0, 28'd0, 32'd0, 32'd0, rdy);
   endtask

   int              n_pop;
   longint unsigned s0;
   logic [15:0]     bp_drop_exp;

   initial begin
      reset_n = 1'b0;
      pkt_v = '0; pkt_store = '0; pkt_addr = '0; pkt_data = '0; ready = 1'b1;
      w_pkt_v = 1'b0; w_store = 1'b1; w_addr = '0; w_data = '0; w_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset v_o", 64'(v), 64'd0);
      chk("reset ch_o", 64'(ch), 64'd0);
      chk("reset stamp_o", stamp, 64'd0);
      chk("reset tag_o", 64'(tag), 64'd0);
      chk("reset drop_cnt_o", 64'(drop_cnt), 64'd0);
      reset_n = 1'b1;
      model_reset();

      // Wrap instance hits at cycles 15 and 16; stamps 15 then 0.
      while (cnt < 50) begin
         w_pkt_v = (cnt == 15 || cnt == 16);
         w_data  = 32'hA00 + 32'(cnt);
         idle(1'b1);
         if (cnt == 17) begin
            chk("wrap v 17", 64'(w_v), 64'd1);
            chk("wrap stamp 15", 64'(w_stamp), 64'd15);
            chk("wrap tag 15", 64'(w_tag), 64'hA0F);
         end
         if (cnt == 18) begin
            chk("wrap v 18", 64'(w_v), 64'd1);
            chk("wrap stamp 0", 64'(w_stamp), 64'd0);
            chk("wrap tag 16", 64'(w_tag), 64'hA10);
         end
         if (cnt == 19) chk("wrap drained", 64'(w_v), 64'd0);
      end
      w_pkt_v = 1'b0;

      // Simultaneous pair at stamp 50 with pointer at 0: ch0 then ch1.
      do_cycle(2'b11, 2'b11, 28'd0, 28'd0, 32'h500, 32'h501, 1'b1);
      idle(1'b1);
      chk("pair50 first v", 64'(v), 64'd1);
      chk("pair50 first ch", 64'(ch), 64'd0);
      chk("pair50 first stamp", stamp, 64'd50);
      idle(1'b1);
      chk("pair50 second ch", 64'(ch), 64'd1);
      chk("pair50 second stamp", stamp, 64'd50);
      while (cnt < 60) idle(1'b1);
      do_cycle(2'b11, 2'b11, 28'd0, 28'd0, 32'h600, 32'h601, 1'b1);
      idle(1'b1);
      chk("pair60 first ch", 64'(ch), 64'd0);
      idle(1'b1);
      chk("pair60 second ch", 64'(ch), 64'd1);
      chk("pair60 second tag", 64'(tag), 64'h601);

      // Single hit on ch1 at counter 100.
      while (cnt < 100) idle(1'b1);
      do_cycle(2'b10, 2'b10, 28'd0, 28'd0, 32'd0, 32'hBEEF, 1'b1);
      chk("hit t+1 v", 64'(v), 64'd0);
      idle(1'b1);
      chk("hit t+2 v", 64'(v), 64'd1);
      chk("hit ch", 64'(ch), 64'd1);
      chk("hit stamp", stamp, 64'd100);
      chk("hit tag", 64'(tag), 64'hBEEF);
      idle(1'b1);

      // Load to the EPA and store to EPA+4 never match.
      do_cycle(2'b11, 2'b10, 28'd0, 28'd4, 32'h1, 32'h2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         chk("nomatch v", 64'(v), 64'd0);
      end
      chk("nomatch drops", 64'(drop_cnt), 64'd0);

      // Backpressure: 12 back-to-back hits on ch0 with ready low.
      s0 = cnt;
      for (int i = 0; i < 12; i++)
         do_cycle(2'b01, 2'b01, 28'd0, 28'd0, 32'hB00 + 32'(i), 32'd0, 1'b0);
      repeat (3) idle(1'b0);
`ifdef BSG_STAT_SNOOP_DROP_COUNT_EN
      bp_drop_exp = 16'd3;
`else
      bp_drop_exp = 16'd0;
`endif
      chk("bp drop ch0", 64'(drop_cnt[15:0]), 64'(bp_drop_exp));
      chk("bp drop ch1", 64'(drop_cnt[31:16]), 64'd0);
      n_pop = 0;
      for (int i = 0; i < 14; i++) begin
         if (v) begin
            chk("bp order", stamp, s0 + longint'(n_pop));
            n_pop++;
         end
         idle(1'b1);
      end
      chk("bp retained", 64'(n_pop), 64'd9);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [1:0]  rv, rs;
         logic [27:0] ra0, ra1;
         rv  = 2'($urandom);
         rs  = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
         ra0 = ($urandom_range(0, 3) == 0) ? 28'd4 : 28'd0;
         ra1 = ($urandom_range(0, 3) == 0) ? 28'd8 : 28'd0;
         do_cycle(rv, rs, ra0, ra1, $urandom, $urandom, ($urandom_range(0, 9) < 6));
      end

      // Reset in the middle of a queued burst.
      repeat (20) idle(1'b1);
      for (int i = 0; i < 3; i++)
         do_cycle(2'b01, 2'b01, 28'd0, 28'd0, 32'hC00 + 32'(i), 32'd0, 1'b0);
      repeat (2) idle(1'b0);
      chk("pre-reset v", 64'(v), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("async reset v_o", 64'(v), 64'd0);
      chk("async reset stamp_o", stamp, 64'd0);
      chk("async reset drop_cnt_o", 64'(drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      repeat (2) idle(1'b1);
      do_cycle(2'b10, 2'b10, 28'd0, 28'd0, 32'd0, 32'h77, 1'b1);
      idle(1'b1);
      chk("post-reset v", 64'(v), 64'd1);
      chk("post-reset stamp", stamp, 64'd2);
      chk("post-reset tag", 64'(tag), 64'h77);
      repeat (3) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_stat_snoop_mc.md
# bsg_manycore_stat_snoop_mc

Multi-channel print-stat snoop for the manycore host/IO complex. Watches `num_ch_p` manycore request streams for stores to the print-stat EPA, timestamps each hit with a free-running cycle counter, and queues `{channel, stamp, tag}` records into a FIFO drained by a valid/ready consumer (profiler or DPI reader). Successor to the single-link, untimestamped, unbuffered print-stat snoop: more channels, buffering, ordering and drop accounting.

## Interface
- `num_ch_p`, 2: number of snooped request channels (1..16).
- `addr_width_p`, 28: EPA width.
- `data_width_p`, 32: packet data / tag width.
- `stat_epa_p`, 0: EPA that identifies a print-stat store.
- `stamp_width_p`, 64: timestamp counter width.
- `fifo_els_p`, 8: output FIFO depth (power of two, ≥2).
- `drop_cnt_width_p`, 16: per-channel drop counter width.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `pkt_v_i` in `num_ch_p`: per-channel request packet valid (snoop only; handshake already completed upstream).
- `pkt_store_i` in `num_ch_p`: packet op is a store.
- `pkt_addr_i` in `num_ch_p*addr_width_p`: per-channel EPA.
- `pkt_data_i` in `num_ch_p*data_width_p`: per-channel data (the tag).
- `v_o` out 1: record available.
- `ready_i` in 1: consumer accepts record.
- `ch_o` out `clog2(num_ch_p)`: source channel.
- `stamp_o` out `stamp_width_p`: cycle count at match.
- `tag_o` out `data_width_p`: print-stat tag.
- `drop_cnt_o` out `num_ch_p*drop_cnt_width_p`: per-channel dropped-record counts.

## Operation
- Match on channel c in cycle t: `pkt_v_i[c] & pkt_store_i[c] & (addr == stat_epa_p)`.
- Stamp counter: 0 after reset, +1 every cycle, wraps modulo 2^`stamp_width_p`. A match captures the counter value of cycle t.
- Per-channel one-entry holding register. Match with empty (or granted-this-cycle) holding reg: load `{stamp, tag}` at end of t. Match with occupied, non-granted reg: record dropped, drop counter c increments.
- Round-robin arbiter over occupied holding regs; one grant per cycle, only when FIFO not full. Pointer resets to channel 0, advances to granted+1 (mod `num_ch_p`).
- Granted entry written to FIFO at end of cycle; holding reg frees at the same edge, and may refill from a same-cycle match.
- FIFO full: no grant; holding regs keep contents; further matches on occupied channels drop.
- Pop when `v_o & ready_i`. Simultaneous push and pop on full FIFO allowed (no stall that cycle).
- Records from one channel leave in match order; cross-channel order follows arbitration.

## Timing
- All outputs registered-state based; reset: `v_o`=0, `ch_o`/`stamp_o`/`tag_o`=0, `drop_cnt_o`=0, holding regs empty, counter 0, RR pointer 0.
- Latency: match in cycle t, empty FIFO, no contention → `v_o`=1 in cycle t+2.
- `ch_o/stamp_o/tag_o` stable while `v_o & ~ready_i`.
- Throughput: one record per cycle sustained.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight and queued records discarded, not counted as drops.
- Drop counters saturate at all-ones.

## Configuration
- `BSG_STAT_SNOOP_DROP_COUNT_EN` defined: per-channel saturating drop counters implemented, `drop_cnt_o` live.
- Undefined: no counter flops; `drop_cnt_o` tied to 0; dropping behaviour otherwise identical.

## Structure
- Shared package `bsg_manycore_stat_snoop_pkg`: record typedef `{ch, stamp, tag}` parameterised by width constants, default `stat_epa_p` constant.
- Sub-module `bsg_manycore_stat_snoop_fifo`: `fifo_els_p`-entry 1r1w FIFO, valid/ready out, full flag, simultaneous push/pop on full.
- Round-robin arbiter and holding regs live in the top.

## Test plan
- Single hit: ch1 store addr=`stat_epa_p`, tag=0xBEEF, counter=100 → cycle t+2 `v_o`=1, `ch_o`=1, `stamp_o`=100, `tag_o`=0xBEEF.
- Non-match: load to `stat_epa_p`, store to `stat_epa_p`+4 → `v_o` stays 0, drop counts 0.
- Simultaneous: ch0,ch1 hit in same cycle at stamp 50 → two records, ch0 then ch1, both `stamp_o`=50; next simultaneous pair after RR at ch0 served ch1 first only if pointer points there (check pointer=0 → ch0 first).
- Backpressure: `ready_i`=0, 12 hits on ch0 one per cycle, `fifo_els_p`=8 → 9 retained (8 FIFO + 1 holding), `drop_cnt_o[ch0]`=3 with macro, 0 without; release `ready_i` → 9 records in stamp order.
- Wrap: `stamp_width_p`=4, hits at cycles 15 and 16 → stamps 15 and 0.
- Reset mid-stream: 3 records queued, pulse `reset_n_i` low → `v_o`=0 immediately, counters 0, no stale record after release.
